// File: rtl/cxu_l1_to_l2_shim.sv
// cxu_l1_to_l2_shim
//   Wraps a fixed-latency, non-stalling L1 extension unit so the host sees a
//   ready/valid (L2) request/response interface. Requests pass straight into
//   the L1 unit. A credit counter tracks in-flight ops, and a DEPTH-entry FIFO
//   holds results until the host takes them.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       host request handshake
//   req_func/data0/data1      host request payload
//   resp_valid/resp_ready     host response handshake
//   resp_status/resp_data     head-of-FIFO response (status 1 = error)
//   l1_req_valid/func/data*   issue port to the L1 unit (combinational)
//   l1_resp_valid/status/data L1 result, LAT cycles after issue
//   overflow                  sticky: L1 result arrived with nothing in flight
`timescale 1ns/1ps

package common_pkg;
  function automatic bit check_param_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

  function automatic bit check_param_pos(input int value);
    return value > 0;
  endfunction

  // Top bit index of a vector that indexes n entries (never narrower than 1 bit).
  function automatic int msb(input int n);
    return (n <= 2) ? 0 : $clog2(n) - 1;
  endfunction
endpackage

module cxu_l1_to_l2_shim
  import common_pkg::*;
#(
  parameter int FUNC_ID_W = 10,
  parameter int XLEN      = 32,
  parameter int LAT       = 2,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FUNC_ID_W-1:0] req_func,
  input  logic [XLEN-1:0]      req_data0,
  input  logic [XLEN-1:0]      req_data1,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_status,
  output logic [XLEN-1:0]      resp_data,
  output logic                 l1_req_valid,
  output logic [FUNC_ID_W-1:0] l1_req_func,
  output logic [XLEN-1:0]      l1_req_data0,
  output logic [XLEN-1:0]      l1_req_data1,
  input  logic                 l1_resp_valid,
  input  logic                 l1_resp_status,
  input  logic [XLEN-1:0]      l1_resp_data,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = msb(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(DEPTH);

  if (!check_param_range(LAT, 0, 15)) begin : g_bad_lat
    $error("cxu_l1_to_l2_shim: LAT must be 0..15");
  end
  if (!check_param_range(DEPTH, 1, 64)) begin : g_bad_depth
    $error("cxu_l1_to_l2_shim: DEPTH must be 1..64");
  end
  if (!check_param_pos(XLEN) || !check_param_pos(FUNC_ID_W)) begin : g_bad_width
    $error("cxu_l1_to_l2_shim: XLEN and FUNC_ID_W must be positive");
  end

  logic [CNT_W-1:0] inflight_q, count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             run_q, overflow_q;
  logic [XLEN:0]    mem [DEPTH];

  logic [CNT_W:0]   used;
  logic             issue, resp_ok, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits come from registered counts only, so a pop frees its slot one
  // cycle later. run_q holds req_ready low until the first edge out of reset.
  assign used      = {1'b0, inflight_q} + {1'b0, count_q};
  assign req_ready = run_q && (used < CREDITS);
  assign issue     = req_valid && req_ready;

  assign l1_req_valid = issue;
  assign l1_req_func  = req_func;
  assign l1_req_data0 = req_data0;
  assign l1_req_data1 = req_data1;

  // With LAT=0 the result comes back in the issue cycle, before the in-flight
  // count has seen the op, so the issue itself counts as a credit.
  assign resp_ok = l1_resp_valid && ((inflight_q != '0) || ((LAT == 0) && issue));

  assign resp_valid  = (count_q != '0);
  assign pop         = resp_valid && resp_ready;
  assign resp_status = mem[rd_ptr_q][XLEN];
  assign resp_data   = mem[rd_ptr_q][XLEN-1:0];
  assign overflow    = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      run_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (l1_resp_valid && !resp_ok) overflow_q <= 1'b1;

      if (issue && !resp_ok)      inflight_q <= inflight_q + CNT_W'(1);
      else if (!issue && resp_ok) inflight_q <= inflight_q - CNT_W'(1);

      if (resp_ok && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!resp_ok && pop) count_q <= count_q - CNT_W'(1);

      if (resp_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_ok) mem[wr_ptr_q] <= {l1_resp_status, l1_resp_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (used <= CREDITS);
  end

endmodule

// File: tb/tb_cxu_l1_to_l2_shim.sv
`timescale 1ns/1ps

module tb_cxu_l1_to_l2_shim;
  localparam int FW  = 10;
  localparam int XW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, resp_ready;
  logic [FW-1:0] req_func;
  logic [XW-1:0] req_data0, req_data1;

  // index 0: DEPTH=4 instance, index 1: DEPTH=3 instance (non power of two)
  logic [1:0]         req_ready, resp_valid, resp_status, l1_req_valid, overflow;
  logic [1:0][XW-1:0] resp_data, l1_req_data0, l1_req_data1, l1_rd;
  logic [1:0][FW-1:0] l1_req_func;
  logic [1:0]         l1_rv, l1_rs;

  always #5 clk = ~clk;

  cxu_l1_to_l2_shim #(.FUNC_ID_W(FW), .XLEN(XW), .LAT(LAT), .DEPTH(4)) dut_d4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_func(req_func),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
    .resp_status(resp_status[0]), .resp_data(resp_data[0]),
    .l1_req_valid(l1_req_valid[0]), .l1_req_func(l1_req_func[0]),
    .l1_req_data0(l1_req_data0[0]), .l1_req_data1(l1_req_data1[0]),
    .l1_resp_valid(l1_rv[0]), .l1_resp_status(l1_rs[0]), .l1_resp_data(l1_rd[0]),
    .overflow(overflow[0])
  );

  cxu_l1_to_l2_shim #(.FUNC_ID_W(FW), .XLEN(XW), .LAT(LAT), .DEPTH(3)) dut_d3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_func(req_func),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
    .resp_status(resp_status[1]), .resp_data(resp_data[1]),
    .l1_req_valid(l1_req_valid[1]), .l1_req_func(l1_req_func[1]),
    .l1_req_data0(l1_req_data0[1]), .l1_req_data1(l1_req_data1[1]),
    .l1_resp_valid(l1_rv[1]), .l1_resp_status(l1_rs[1]), .l1_resp_data(l1_rd[1]),
    .overflow(overflow[1])
  );

  int nerr = 0;
  int nchk = 0;

  // Reference model: accepted-but-unconsumed ops with their issue cycle and
  // expected {status,result}; L1 model: pending results with due cycle and
  // the reset epoch they were issued in.
  int unsigned sb_t  [2][256];
  logic [XW:0] sb_v  [2][256];
  int          sb_h  [2];
  int          sb_n  [2];
  int unsigned l1_due[2][256];
  int          l1_ep [2][256];
  logic [XW:0] l1_val[2][256];
  int          l1_h  [2];
  int          l1_n  [2];
  int unsigned cyc = 0;
  int          epoch = 0;
  logic        en = 1'b0;
  logic        inj = 1'b0;
  logic [1:0]  exp_ovf = 2'b00;
  int          acc [2];

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic logic [XW:0] l1_op(input logic [FW-1:0] f, input logic [XW-1:0] a,
                                        input logic [XW-1:0] b);
    logic [XW-1:0] s;
    s = a + b;
    return {f[FW-1], s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] from_q, exp_rdy, exp_rv, iss;
    logic [1:0][FW-1:0] ifn;
    logic [1:0][XW-1:0] id0, id1;
    logic stale;
    for (int k = 0; k < 2; k++) begin
      from_q[k] = (l1_n[k] > 0) && (l1_due[k][l1_h[k] % 256] == cyc);
      l1_rv[k]  = inj | from_q[k];
      {l1_rs[k], l1_rd[k]} = from_q[k] ? l1_val[k][l1_h[k] % 256] : {1'b0, 32'hdead_beef};
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdy[k] = en && !rst && (sb_n[k] < dep(k));
      exp_rv[k]  = (sb_n[k] > 0) && (cyc >= sb_t[k][sb_h[k] % 256] + LAT + 1);
      chk($sformatf("req_ready[%0d] cyc%0d", k, cyc), req_ready[k], exp_rdy[k]);
      chk($sformatf("resp_valid[%0d] cyc%0d", k, cyc), resp_valid[k], exp_rv[k]);
      if (exp_rv[k]) begin
        chk($sformatf("resp_data[%0d] cyc%0d", k, cyc), resp_data[k], sb_v[k][sb_h[k] % 256][XW-1:0]);
        chk($sformatf("resp_status[%0d] cyc%0d", k, cyc), resp_status[k], sb_v[k][sb_h[k] % 256][XW]);
      end
      chk($sformatf("l1_req_valid[%0d] cyc%0d", k, cyc), l1_req_valid[k], req_valid && exp_rdy[k]);
      if (req_valid && exp_rdy[k]) begin
        chk($sformatf("l1_req_func[%0d]", k), l1_req_func[k], req_func);
        chk($sformatf("l1_req_data0[%0d]", k), l1_req_data0[k], req_data0);
        chk($sformatf("l1_req_data1[%0d]", k), l1_req_data1[k], req_data1);
      end
      chk($sformatf("overflow[%0d] cyc%0d", k, cyc), overflow[k], exp_ovf[k]);
      iss[k] = l1_req_valid[k];
      ifn[k] = l1_req_func[k];
      id0[k] = l1_req_data0[k];
      id1[k] = l1_req_data1[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      stale = 1'b0;
      if (from_q[k]) begin
        stale = (l1_ep[k][l1_h[k] % 256] != epoch);
        l1_h[k]++;
        l1_n[k]--;
      end
      if (!rst && (inj || stale)) exp_ovf[k] = 1'b1;
      if (req_valid && exp_rdy[k]) begin
        sb_t[k][(sb_h[k] + sb_n[k]) % 256] = cyc;
        sb_v[k][(sb_h[k] + sb_n[k]) % 256] = l1_op(req_func, req_data0, req_data1);
        sb_n[k]++;
      end
      if (exp_rv[k] && resp_ready) begin
        sb_h[k]++;
        sb_n[k]--;
      end
      if (iss[k]) begin
        l1_due[k][(l1_h[k] + l1_n[k]) % 256] = cyc + LAT;
        l1_ep [k][(l1_h[k] + l1_n[k]) % 256] = epoch;
        l1_val[k][(l1_h[k] + l1_n[k]) % 256] = l1_op(ifn[k], id0[k], id1[k]);
        l1_n[k]++;
        acc[k]++;
      end
    end
    en = !rst;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    epoch++;
    en = 1'b0;
    exp_ovf = 2'b00;
    for (int k = 0; k < 2; k++) sb_n[k] = 0;
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  task automatic rand_req();
    req_func  = FW'($urandom);
    req_data0 = $urandom;
    req_data1 = $urandom;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_func = '0; req_data0 = '0; req_data1 = '0;
    l1_rv = '0; l1_rs = '0; l1_rd = '0;
    for (int k = 0; k < 2; k++) begin
      sb_h[k] = 0; sb_n[k] = 0; l1_h[k] = 0; l1_n[k] = 0; acc[k] = 0;
    end
    @(negedge clk);
    do_reset(2);
    tick();

    // single op: 5 + 7 with func 3
    req_valid = 1'b1; req_func = 10'd3; req_data0 = 32'd5; req_data1 = 32'd7;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("single_valid", resp_valid[0], 1'b1);
    chk("single_data", resp_data[0], 32'd12);
    chk("single_status", resp_status[0], 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("single_popped", resp_valid[0], 1'b0);

    // reset with two ops in flight; the late second result must flag overflow
    req_valid = 1'b1; rand_req(); tick();
    rand_req(); tick();
    req_valid = 1'b0;
    do_reset(1);
    tick();
    chk("rst_ready", req_ready[0], 1'b1);
    chk("rst_resp_valid", resp_valid[0], 1'b0);
    chk("rst_overflow", overflow[0], 1'b1);
    do_reset(1);
    tick();
    chk("rst_ovf_cleared", overflow[0], 1'b0);

    // streaming
    resp_ready = 1'b1;
    acc[0] = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; rand_req();
      chk("stream_ready", req_ready[0], 1'b1);
      tick();
    end
    req_valid = 1'b0;
    chk("stream_accepted", acc[0], 16);
    repeat (6) tick();

    // backpressure
    resp_ready = 1'b0;
    acc[0] = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; rand_req();
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc[0], 4);
    chk("bp_ready_low", req_ready[0], 1'b0);
    resp_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", req_ready[0], 1'b1);
    repeat (5) tick();

    // unexpected L1 response while idle
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("perr_overflow", overflow[0], 1'b1);
    chk("perr_resp_valid", resp_valid[0], 1'b0);
    tick();
    chk("perr_sticky", overflow[0], 1'b1);

    // random traffic, both depths, then a clean reset and more
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 300; i++) begin
        req_valid  = ($urandom_range(0, 9) < 7);
        resp_ready = ($urandom_range(0, 9) < 6);
        rand_req();
        tick();
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      repeat (8) tick();
      chk("drained_d4", resp_valid[0], 1'b0);
      chk("drained_d3", resp_valid[1], 1'b0);
      if (r == 0) begin
        do_reset(1);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
